// File: rtl/count_fault_monitor.sv
// Sequence and syndrome monitor for the fault-tolerant 3-bit counter.
// Keeps saturating error statistics and raises a sticky alarm on a windowed error threshold.
module count_fault_monitor #(
  parameter int ERR_W        = 8,
  parameter int WINDOW       = 16,
  parameter int ALARM_THRESH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [2:0]       count_in,
  input  logic [2:0]       syndrome_in,
  input  logic             clear,
  output logic             locked,
  output logic             alarm,
  output logic             seq_err,
  output logic             corr_err,
  output logic [ERR_W-1:0] corr_count,
  output logic [ERR_W-1:0] uncorr_count,
  output logic [ERR_W-1:0] seq_count,
  output logic [2:0]       last_err_bit
);

  localparam int IDX_W = $clog2(WINDOW);
  localparam int CNT_W = $clog2(WINDOW + 1);
  localparam logic [IDX_W-1:0] LAST_IDX_C = IDX_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] THRESH_C   = CNT_W'(ALARM_THRESH);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_ALARM    = 2'd2
  } state_t;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + {{(ERR_W-1){1'b0}}, 1'b1};
  endfunction

  state_t            state_r, state_nxt_s;
  logic [2:0]        prev_r, prev_inc_s;
  logic [IDX_W-1:0]  win_idx_r;
  logic [CNT_W-1:0]  win_err_r, w_s;
  logic [ERR_W-1:0]  corr_count_r, uncorr_count_r, seq_count_r;
  logic [2:0]        last_err_bit_r;
  logic              seq_err_r, corr_err_r, locked_r, alarm_r;
  logic              seq_bad_s, is_corr_s, is_unc_s, event_s, thresh_hit_s;

  assign prev_inc_s   = prev_r + 3'd1;
  assign seq_bad_s    = (state_r != ST_UNLOCKED) && (count_in != prev_inc_s);
  assign is_unc_s     = (syndrome_in == 3'd7);
  assign is_corr_s    = (syndrome_in != 3'd0) && !is_unc_s;
  assign event_s      = seq_bad_s || (syndrome_in != 3'd0);
  assign w_s          = win_err_r + CNT_W'(event_s);
  assign thresh_hit_s = (w_s >= THRESH_C);

  // Next-state logic; the window closing sample still counts toward its threshold.
  always_comb begin
    state_nxt_s = state_r;
    if (clear) begin
      state_nxt_s = ST_UNLOCKED;
    end else if (in_valid) begin
      case (state_r)
        ST_UNLOCKED: state_nxt_s = ST_LOCKED;
        ST_LOCKED:   state_nxt_s = (is_unc_s || thresh_hit_s) ? ST_ALARM : ST_LOCKED;
        ST_ALARM:    state_nxt_s = ST_ALARM;
        default:     state_nxt_s = ST_UNLOCKED;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State register with registered locked/alarm views of the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_UNLOCKED;
      locked_r <= 1'b0;
      alarm_r  <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      locked_r <= (state_nxt_s != ST_UNLOCKED);
      alarm_r  <= (state_nxt_s == ST_ALARM);
    end
  end

  // Statistics, pulses and window bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_r         <= 3'd0;
      win_idx_r      <= '0;
      win_err_r      <= '0;
      corr_count_r   <= '0;
      uncorr_count_r <= '0;
      seq_count_r    <= '0;
      last_err_bit_r <= 3'd0;
      seq_err_r      <= 1'b0;
      corr_err_r     <= 1'b0;
    end else if (clear) begin
      win_idx_r      <= '0;
      win_err_r      <= '0;
      corr_count_r   <= '0;
      uncorr_count_r <= '0;
      seq_count_r    <= '0;
      last_err_bit_r <= 3'd0;
      seq_err_r      <= 1'b0;
      corr_err_r     <= 1'b0;
    end else if (in_valid) begin
      prev_r     <= count_in;
      seq_err_r  <= seq_bad_s;
      corr_err_r <= is_corr_s;
      if (is_corr_s) begin
        corr_count_r <= sat_inc(corr_count_r);
      end
      if (is_unc_s) begin
        uncorr_count_r <= sat_inc(uncorr_count_r);
      end
      if (seq_bad_s) begin
        seq_count_r <= sat_inc(seq_count_r);
      end
      if (syndrome_in != 3'd0) begin
        last_err_bit_r <= syndrome_in;
      end
      if (state_r == ST_UNLOCKED) begin
        win_idx_r <= IDX_W'(1'b1);
        win_err_r <= CNT_W'(syndrome_in != 3'd0);
      end else if (win_idx_r == LAST_IDX_C) begin
        win_idx_r <= '0;
        win_err_r <= '0;
      end else begin
        win_idx_r <= win_idx_r + IDX_W'(1'b1);
        win_err_r <= w_s;
      end
    end else begin
      seq_err_r  <= 1'b0;
      corr_err_r <= 1'b0;
    end
  end

  assign locked       = locked_r;
  assign alarm        = alarm_r;
  assign seq_err      = seq_err_r;
  assign corr_err     = corr_err_r;
  assign corr_count   = corr_count_r;
  assign uncorr_count = uncorr_count_r;
  assign seq_count    = seq_count_r;
  assign last_err_bit = last_err_bit_r;

endmodule

// File: doc/count_fault_monitor.md
# count_fault_monitor

Downstream consumer of the fault-tolerant 3-bit up-counter. Each valid cycle it samples the corrected count and the Hamming error syndrome that produced it. It checks that the count advances by exactly one modulo 8, and keeps saturating statistics of corrected, uncorrectable and sequence errors. A windowed alarm state machine flags a counter that is faulting too often.

## Interface
Parameters:
- ERR_W, 8, width of each statistics counter
- WINDOW, 16, number of valid samples per alarm window (≥2)
- ALARM_THRESH, 4, error events within one window that raise the alarm (1..WINDOW)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- in_valid  in  1  count_in/syndrome_in are valid this cycle
- count_in  in  3  corrected count from the counter stage
- syndrome_in  in  3  error syndrome; 0 = clean, 1..6 = corrected codeword bit position, 7 = uncorrectable
- clear  in  1  synchronous statistics/alarm clear
- locked  out  1  a reference count has been captured
- alarm  out  1  sticky alarm
- seq_err  out  1  one-cycle pulse: sequence break detected
- corr_err  out  1  one-cycle pulse: syndrome 1..6 seen
- corr_count  out  ERR_W  saturating count of corrected errors
- uncorr_count  out  ERR_W  saturating count of syndrome 7
- seq_count  out  ERR_W  saturating count of sequence breaks
- last_err_bit  out  3  syndrome of most recent nonzero-syndrome sample

## Operation
States: UNLOCKED, LOCKED, ALARM.
- Reset (reset=0): state UNLOCKED. All outputs 0. Internal prev, win_idx and win_err are 0.
- clear=1 (synchronous; overrides in_valid in the same cycle, so that sample is discarded):
  - state becomes UNLOCKED
  - all counters, last_err_bit, win_idx and win_err become 0
  - pulses are 0
- UNLOCKED, in_valid=1:
  - prev ← count_in; state ← LOCKED
  - no sequence check; the syndrome is still processed (counters and last_err_bit)
  - win_idx ← 1; win_err ← 1 if syndrome ≠ 0, else 0
- LOCKED or ALARM, in_valid=1:
  - seq_bad = (count_in ≠ (prev+1) mod 8). 7→0 is legal wrap.
  - prev ← count_in unconditionally, so the monitor resyncs after a break.
  - syndrome 1..6: corr_count+1, corr_err pulse, last_err_bit ← syndrome.
  - syndrome 7: uncorr_count+1, last_err_bit ← 7, state ← ALARM immediately.
  - seq_bad: seq_count+1, seq_err pulse.
  - event = seq_bad OR syndrome ≠ 0, at most one event per sample.
  - w = win_err + event. If w ≥ ALARM_THRESH, state ← ALARM.
  - If win_idx = WINDOW−1: win_idx ← 0, win_err ← 0. The closing sample counts toward the old window's threshold check.
  - Otherwise: win_idx+1, win_err ← w.
- ALARM: statistics keep updating. alarm stays 1 until clear or reset. Windows keep rolling, with no effect on state.
- in_valid=0: nothing changes and pulses are 0.
- All counters saturate at 2^ERR_W−1 and never wrap. win_err is internal, sized ceil(log2(WINDOW+1)).
- locked = (state ≠ UNLOCKED); alarm = (state = ALARM).

## Timing
- All outputs are registered. Response appears on the cycle after the sampling edge, i.e. one-cycle latency from in_valid.
- seq_err and corr_err are high for exactly one cycle per offending sample. Back-to-back bad samples give back-to-back pulses.
- The alarm rises one cycle after the sample that reaches the threshold or carries syndrome 7.
- No input handshake: the block accepts every in_valid cycle, including back-to-back, with no backpressure.
- Asynchronous reset mid-operation clears everything immediately. The first valid sample after reset release only locks and is never flagged as a sequence break.

## Test plan
- Reset/idle: hold reset=0, then release with in_valid=0 for 5 cycles → locked=0, alarm=0, all counters and last_err_bit 0.
- Clean run with wrap: 20 valid samples, count 0,1,…,7,0,… and syndrome 0 → locked=1 after the first sample; seq_count=0, corr_count=0, alarm=0.
- Corrected error: count sequence 2,3,4 with syndrome 3 on count 3 → corr_err pulses once, corr_count=1, last_err_bit=3, alarm=0.
- Sequence break: counts 0,1,3,4 → single seq_err pulse one cycle after count 3 is sampled, seq_count=1; the following 4 raises no error (resynced).
- Threshold with window rollover (defaults):
  - errors on samples 2, 5, 9 and 14 of one window → alarm=1 the cycle after sample 14
  - separately, 3 errors at the end of a window and 3 at the start of the next → alarm stays 0
  - then syndrome 7 → alarm=1, uncorr_count=1
- Clear/saturation:
  - clear asserted with in_valid=1 → sample ignored, state UNLOCKED, counters 0
  - ERR_W=2 with 5 corrected errors → corr_count holds at 3
